// File: rtl/wb_reg_bridge.sv
// -----------------------------------------------------------------------------
// wb_reg_bridge
//
// Wishbone B4 classic slave to single-outstanding reg-bus bridge. A Wishbone
// request is registered onto the reg bus and held there until the peripheral
// answers with reg_ack. The bridge then returns a one-cycle wbs_ack_o, carrying
// read data for reads and zero for writes. If the master drops wbs_cyc_i while
// the request is outstanding, the reg-bus transfer still completes, but its
// response is discarded.
//
// Optional feature (macro WB_REG_BRIDGE_TIMEOUT_EN):
//   If reg_ack does not arrive within TIMEOUT+1 REQ cycles, the request is
//   withdrawn and a one-cycle wbs_err_o is returned instead. Without the macro
//   the bridge waits for reg_ack indefinitely and wbs_err_o is tied low.
//
// Parameters:
//   AW      reg-bus address width
//   DW      data width (byte enables are DW/8 wide)
//   TIMEOUT REQ-cycle limit before an error is returned (1..65535)
//
// Ports:
//   app_clk, app_rst              clock, synchronous active-high reset
//   wbs_cyc_i/stb_i/we_i          Wishbone cycle, strobe, write enable
//   wbs_adr_i/dat_i/sel_i         Wishbone address, write data, byte selects
//   wbs_dat_o/ack_o/err_o         Wishbone read data, ack, error
//   reg_cs/wr/addr/wdata/be       reg-bus request, held until reg_ack
//   reg_rdata/reg_ack             reg-bus read data and acknowledge
// -----------------------------------------------------------------------------
module wb_reg_bridge #(
   parameter int AW      = 9,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic            app_clk,
   input  logic            app_rst,
   input  logic            wbs_cyc_i,
   input  logic            wbs_stb_i,
   input  logic            wbs_we_i,
   input  logic [AW-1:0]   wbs_adr_i,
   input  logic [DW-1:0]   wbs_dat_i,
   input  logic [DW/8-1:0] wbs_sel_i,
   output logic [DW-1:0]   wbs_dat_o,
   output logic            wbs_ack_o,
   output logic            wbs_err_o,
   output logic            reg_cs,
   output logic            reg_wr,
   output logic [AW-1:0]   reg_addr,
   output logic [DW-1:0]   reg_wdata,
   output logic [DW/8-1:0] reg_be,
   input  logic [DW-1:0]   reg_rdata,
   input  logic            reg_ack
);

   localparam int BW = DW / 8;

   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("wb_reg_bridge: TIMEOUT must be in 1..65535");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2,
      DROP = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            reg_cs_q, reg_cs_d;
   logic            reg_wr_q, reg_wr_d;
   logic [AW-1:0]   reg_addr_q, reg_addr_d;
   logic [DW-1:0]   reg_wdata_q, reg_wdata_d;
   logic [BW-1:0]   reg_be_q, reg_be_d;
   logic [DW-1:0]   wbs_dat_q, wbs_dat_d;
   logic            wbs_ack_q, wbs_ack_d;
   logic            drop_q, drop_d;   // master abandoned the cycle while in REQ
   logic            abort;

`ifdef WB_REG_BRIDGE_TIMEOUT_EN
   localparam int            CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TERM = CW'(TIMEOUT);

   logic [CW-1:0]   cnt_q, cnt_d;
   logic            wbs_err_q, wbs_err_d;
   logic            expired;
`endif

   always_comb begin
      state_d     = state_q;
      reg_cs_d    = reg_cs_q;
      reg_wr_d    = reg_wr_q;
      reg_addr_d  = reg_addr_q;
      reg_wdata_d = reg_wdata_q;
      reg_be_d    = reg_be_q;
      drop_d      = drop_q;
      wbs_ack_d   = 1'b0;
      wbs_dat_d   = '0;
      // A cyc drop seen in any REQ cycle, including the reg_ack cycle, kills the response
      abort       = drop_q | ~wbs_cyc_i;
`ifdef WB_REG_BRIDGE_TIMEOUT_EN
      cnt_d       = cnt_q;
      wbs_err_d   = 1'b0;
      expired     = (cnt_q == TERM);
`endif

      case (state_q)
         IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               reg_cs_d    = 1'b1;
               reg_wr_d    = wbs_we_i;
               reg_addr_d  = wbs_adr_i;
               reg_wdata_d = wbs_dat_i;
               reg_be_d    = wbs_sel_i;
               drop_d      = 1'b0;
`ifdef WB_REG_BRIDGE_TIMEOUT_EN
               cnt_d       = '0;
`endif
               state_d     = REQ;
            end
         end

         REQ: begin
            drop_d = abort;
            if (reg_ack) begin
               reg_cs_d = 1'b0;
               reg_wr_d = 1'b0;
               if (abort) begin
                  state_d = DROP;
               end else begin
                  state_d   = RESP;
                  wbs_ack_d = 1'b1;
                  wbs_dat_d = reg_wr_q ? '0 : reg_rdata;
               end
            end
`ifdef WB_REG_BRIDGE_TIMEOUT_EN
            // reg_ack takes priority over the terminal count
            else if (expired) begin
               reg_cs_d  = 1'b0;
               reg_wr_d  = 1'b0;
               state_d   = abort ? DROP : RESP;
               wbs_err_d = ~abort;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
`endif
         end

         // Single response/discard cycle; no new request accepted here
         RESP:    state_d = IDLE;
         DROP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge app_clk) begin
      if (app_rst) begin
         state_q     <= IDLE;
         reg_cs_q    <= 1'b0;
         reg_wr_q    <= 1'b0;
         reg_addr_q  <= '0;
         reg_wdata_q <= '0;
         reg_be_q    <= '0;
         drop_q      <= 1'b0;
         wbs_ack_q   <= 1'b0;
         wbs_dat_q   <= '0;
`ifdef WB_REG_BRIDGE_TIMEOUT_EN
         cnt_q       <= '0;
         wbs_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         reg_cs_q    <= reg_cs_d;
         reg_wr_q    <= reg_wr_d;
         reg_addr_q  <= reg_addr_d;
         reg_wdata_q <= reg_wdata_d;
         reg_be_q    <= reg_be_d;
         drop_q      <= drop_d;
         wbs_ack_q   <= wbs_ack_d;
         wbs_dat_q   <= wbs_dat_d;
`ifdef WB_REG_BRIDGE_TIMEOUT_EN
         cnt_q       <= cnt_d;
         wbs_err_q   <= wbs_err_d;
`endif
      end
   end

   assign reg_cs    = reg_cs_q;
   assign reg_wr    = reg_wr_q;
   assign reg_addr  = reg_addr_q;
   assign reg_wdata = reg_wdata_q;
   assign reg_be    = reg_be_q;
   assign wbs_dat_o = wbs_dat_q;
   assign wbs_ack_o = wbs_ack_q;
`ifdef WB_REG_BRIDGE_TIMEOUT_EN
   assign wbs_err_o = wbs_err_q;
`else
   assign wbs_err_o = 1'b0;
`endif

endmodule

// File: doc/wb_reg_bridge.md
Name: wb_reg_bridge

Overview:
Wishbone B4 classic slave that converts host Wishbone cycles into the single-outstanding reg-bus protocol (reg_cs/reg_wr/reg_addr/reg_wdata/reg_be -> reg_rdata/reg_ack). It drives the peripheral wrapper that hosts the USB 1.1 host register file. It sits directly upstream of that wrapper, between the interconnect slave port and the reg bus.
It registers each request and holds it stable until the peripheral acknowledges. It returns read data and a one-cycle Wishbone ack, and optionally converts a missing acknowledge into a bus error.

Parameters:
AW, 9, reg-bus address width (bits [8:6] select the sub-peripheral)
DW, 32, data width; byte-enable width is DW/8
TIMEOUT, 255, cycles in REQ without reg_ack before an error is returned (only with the optional feature); legal range 1..65535

Ports:
app_clk  in  1  single clock for both bus sides
app_rst  in  1  synchronous reset, active-high
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  1 = write
wbs_adr_i  in  AW  byte-free register address
wbs_dat_i  in  DW  write data
wbs_sel_i  in  DW/8  byte enables
wbs_dat_o  out  DW  read data, valid while wbs_ack_o=1
wbs_ack_o  out  1  one-cycle acknowledge
wbs_err_o  out  1  one-cycle error (timeout)
reg_cs  out  1  reg-bus request, held until reg_ack
reg_wr  out  1  reg-bus write
reg_addr  out  AW  reg-bus address
reg_wdata  out  DW  reg-bus write data
reg_be  out  DW/8  reg-bus byte enables
reg_rdata  in  DW  reg-bus read data, valid with reg_ack
reg_ack  in  1  reg-bus acknowledge, one or more cycles

Behaviour:
- Clocking and reset: single clock app_clk; app_rst is synchronous, active-high.
- On reset, all outputs are 0 and the FSM is IDLE. Reset asserted mid-transaction abandons it: reg_cs=0 and no ack/err on the next edge.
- FSM states: IDLE, REQ, RESP, DROP.
- IDLE:
  - If wbs_cyc_i & wbs_stb_i, capture adr/dat/sel/we into reg_addr/reg_wdata/reg_be/reg_wr, set reg_cs=1 and go to REQ.
  - reg_ack arriving in IDLE is ignored.
- REQ:
  - reg_cs=1; reg_addr/reg_wdata/reg_be/reg_wr are held constant.
  - On reg_ack=1: reg_cs=0 at the next edge. For reads, wbs_dat_o <= reg_rdata; for writes, wbs_dat_o <= 0. wbs_ack_o=1 for one cycle (RESP).
  - If wbs_cyc_i was sampled low at any point during REQ, the response is discarded: on reg_ack go to DROP instead of RESP, with no ack and no err.
- RESP: wbs_ack_o (or wbs_err_o) high for exactly one cycle, then IDLE.
- DROP: one cycle with all Wishbone outputs 0, then IDLE.
- Latency:
  - stb sampled at edge N -> reg_cs high from N.
  - reg_ack sampled at edge M -> wbs_ack_o high from M for one cycle.
  - Minimum 3 cycles stb->ack, with combinational reg_ack in the first reg_cs cycle.
- Back-to-back: no new request is accepted in RESP/DROP. stb still high in the first IDLE cycle after an ack is treated as a new request (classic master drops stb after ack).
- In IDLE: reg_wr=0; reg_addr/reg_wdata/reg_be hold their last values.
- wbs_dat_o returns to 0 the cycle after RESP.

Optional Feature:
Macro: WB_REG_BRIDGE_TIMEOUT_EN
- Defined:
  - A timeout counter of width clog2(TIMEOUT+1) clears on entry to REQ and increments each REQ cycle without reg_ack.
  - When the counter reaches TIMEOUT with reg_ack=0: reg_cs=0 at the next edge, wbs_dat_o=0, wbs_err_o=1 for one cycle (RESP), then IDLE.
  - reg_ack and the terminal count in the same cycle: ack wins (normal completion).
  - A timeout after cyc was dropped goes to DROP.
- Undefined: no counter; REQ waits indefinitely; wbs_err_o tied 0.

Test Plan:
- Read: wbs_adr_i=9'h080, we=0, sel=4'hF; peripheral asserts reg_ack 2 cycles after reg_cs with reg_rdata=32'h1234_5678 -> reg_cs high exactly 2 cycles, reg_addr=9'h080, then wbs_ack_o one cycle with wbs_dat_o=32'h1234_5678.
- Write: adr=9'h084, dat=32'hA5A5_0F0F, sel=4'b0011, immediate reg_ack -> reg_wr=1, reg_wdata=32'hA5A5_0F0F, reg_be=4'b0011 for one reg_cs cycle; wbs_ack_o at cycle 3, wbs_dat_o=0.
- Back-to-back: two reads with stb held high across the ack -> second reg_cs starts the cycle after RESP; exactly two acks; reg_cs is never high in RESP.
- Abort: drop wbs_cyc_i 1 cycle after reg_cs; reg_ack 4 cycles later -> reg_cs held until reg_ack, no wbs_ack_o/wbs_err_o, FSM back to IDLE.
- Timeout (macro on, TIMEOUT=8): read to adr=9'h000 (unmapped, no reg_ack) -> reg_cs high 9 cycles, then wbs_err_o=1 for one cycle with wbs_dat_o=0. Repeat with reg_ack in the 9th cycle -> wbs_ack_o, no err. Macro off -> reg_cs stays high and wbs_err_o stays 0.
- Reset mid-REQ: app_rst=1 for one cycle while reg_cs=1 -> all outputs 0 next edge; a later reg_ack is ignored; a new request completes normally.
